instruction_encoder: RTL
========================

# instruction_encoder

Packs instruction fields into 16-bit instruction words and streams them into instruction memory at consecutive addresses. It is the inverse of the instruction field decoder: every word it emits decodes back to the same op_code, A/B indices, ext_op_code and low immediate byte. It sits between the program loader/debug front end and the instruction memory write port, with a small FIFO that absorbs memory backpressure.

## Interface

Parameters:
- WIDTH, 16, instruction word width
- REG_BITS, 4, register index width
- OP_CODE_BITS, 4, opcode width
- EXT_OP_CODE_BITS, 4, extended opcode width
- ADDR_BITS, 8, instruction memory address width
- FIFO_DEPTH, 4, encoded-word buffer depth (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  field set valid
- in_ready  out  1  encoder can accept a field set
- fmt  in  1  0 = register format, 1 = immediate format
- op_code  in  OP_CODE_BITS
- A_index  in  REG_BITS
- ext_op_code  in  EXT_OP_CODE_BITS  (used only when fmt=0)
- B_index  in  REG_BITS  (used only when fmt=0)
- immediate  in  8  (used only when fmt=1)
- load_addr  in  1  one-cycle pulse, loads start_addr into the write pointer
- start_addr  in  ADDR_BITS
- mem_we  out  1  write request to instruction memory
- mem_addr  out  ADDR_BITS  write address
- mem_wdata  out  WIDTH  encoded word
- mem_ready  in  1  memory accepts the write this cycle
- wrapped  out  1  sticky: write pointer rolled over from 2^ADDR_BITS−1 to 0
- count  out  log2(FIFO_DEPTH)+1  words buffered

## Operation

- Encoding: fmt=0 → {op_code, A_index, ext_op_code, B_index}; fmt=1 → {op_code, A_index, immediate}. Bits [15:12]=op, [11:8]=A, [7:0]=ext/B or imm.
- Accept: a field set is accepted on a rising edge where in_valid && in_ready. The encoded word is pushed into the FIFO.
- in_ready = (count < FIFO_DEPTH) and not stalled (see Configuration). A push is never taken when full, even if a pop happens in the same cycle.
- FSM: two states.
  - IDLE: count==0, mem_we=0. Goes to WRITE when count becomes nonzero.
  - WRITE: mem_we=1, mem_wdata=FIFO head, mem_addr=write pointer. On mem_we && mem_ready, pop the head and increment mem_addr modulo 2^ADDR_BITS. Returns to IDLE when the last word pops and no push occurs.
- mem_wdata and mem_addr stay stable while mem_we=1 && mem_ready=0.
- Simultaneous push and pop: count is unchanged and order is preserved (FIFO).
- load_addr: mem_addr ← start_addr and wrapped ← 0. It takes priority over an increment in the same cycle. Pending buffered words are written starting at the new address.
- Wrap: when an increment takes mem_addr from all-ones to 0, wrapped ← 1.
- Reset (asynchronous, any time, including mid-burst): FIFO flushed; count=0, mem_we=0, mem_addr=0, mem_wdata=0, wrapped=0, in_ready=1, state IDLE.

## Timing

- Latency: a word accepted at edge N appears on mem_wdata with mem_we=1 in the cycle after edge N.
- Throughput: one word per cycle while mem_ready=1.
- All outputs are registered or derived only from registered state. There is no combinational path from in_valid, or from any field input, to any output.
- in_ready depends on count and stall state only, not on mem_ready in the same cycle.

## Configuration

- INSTR_ENC_WRAP_STOP_EN defined: once wrapped=1, the encoder stalls.
  - in_ready=0 and mem_we=0; buffered words are held.
  - A load_addr pulse clears the stall.
  - The write that caused the wrap itself completes at address all-ones.
- Undefined: writes continue past the wrap to address 0, 1, …. wrapped is only a status flag.

## Test plan

- Reset then push fmt=0, op=3, A=2, ext=5, B=7 with mem_ready=1 → next cycle mem_we=1, mem_addr=0, mem_wdata=16'h3257; mem_addr=1 after the pop.
- Push fmt=1, op=A, A=4, imm=8'hC3 → mem_wdata=16'hA4C3. Feeding this word to the field decoder returns immediate 16'h00C3, op A, A index 4.
- Hold mem_ready=0 and push 5 sets → in_ready drops after 4 accepts and count=4. Release mem_ready → 4 words written at consecutive addresses in order, then in_ready=1.
- load_addr with start_addr=8'hFE, then push 3 words → addresses FE, FF, 00 and wrapped=1.
  - With INSTR_ENC_WRAP_STOP_EN: only FE and FF are written. The third word is held, in_ready=0, until load_addr.
- Assert rst_n=0 mid-burst with count=3 → outputs immediately at reset values. After release, no stale words are written.

Source files
------------

// File: rtl/instruction_encoder_if.sv
// ---------------------------------------------------------------------------
// instruction_encoder_if
//   Groups the two streaming sides of the instruction encoder:
//     - field-set handshake: in_valid / in_ready plus fmt, op_code, A_index,
//       ext_op_code, B_index and immediate
//     - instruction-memory write port: mem_we, mem_addr, mem_wdata, mem_ready
//   Modports:
//     master : the environment (program loader and instruction memory)
//     slave  : the encoder itself
// ---------------------------------------------------------------------------
interface instruction_encoder_if #(
    parameter int WIDTH            = 16,
    parameter int REG_BITS         = 4,
    parameter int OP_CODE_BITS     = 4,
    parameter int EXT_OP_CODE_BITS = 4,
    parameter int ADDR_BITS        = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        fmt;
    logic [OP_CODE_BITS-1:0]     op_code;
    logic [REG_BITS-1:0]         A_index;
    logic [EXT_OP_CODE_BITS-1:0] ext_op_code;
    logic [REG_BITS-1:0]         B_index;
    logic [7:0]                  immediate;
    logic                        mem_we;
    logic [ADDR_BITS-1:0]        mem_addr;
    logic [WIDTH-1:0]            mem_wdata;
    logic                        mem_ready;

    modport master (
        output in_valid, fmt, op_code, A_index, ext_op_code, B_index, immediate, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, fmt, op_code, A_index, ext_op_code, B_index, immediate, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
//   Packs instruction fields into WIDTH-bit words and streams them into the
//   instruction memory at consecutive addresses, buffering up to FIFO_DEPTH
//   words to absorb memory backpressure.
//     fmt=0 : {op_code, A_index, ext_op_code, B_index}
//     fmt=1 : {op_code, A_index, immediate}
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     bus (slave)  : field-set handshake and memory write port
//     load_addr    : one-cycle pulse, loads start_addr into the write pointer
//     start_addr   : new write pointer value
//     wrapped      : sticky, write pointer rolled over from all-ones to 0
//     count        : number of buffered words
//   Optional feature macro: INSTR_ENC_WRAP_STOP_EN
//     When defined, the encoder stalls (in_ready=0, mem_we=0) once wrapped is
//     set, until the next load_addr pulse.
// ---------------------------------------------------------------------------
module instruction_encoder #(
    parameter int WIDTH            = 16,
    parameter int REG_BITS         = 4,
    parameter int OP_CODE_BITS     = 4,
    parameter int EXT_OP_CODE_BITS = 4,
    parameter int ADDR_BITS        = 8,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    instruction_encoder_if.slave          bus,
    input  logic                          load_addr,
    input  logic [ADDR_BITS-1:0]          start_addr,
    output logic                          wrapped,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam logic [PTR_BITS:0]    FULL_COUNT = (PTR_BITS+1)'(FIFO_DEPTH);
    localparam logic [PTR_BITS:0]    CNT_ONE    = (PTR_BITS+1)'(1);
    localparam logic [PTR_BITS:0]    CNT_ZERO   = (PTR_BITS+1)'(0);
    localparam logic [PTR_BITS-1:0]  PTR_ONE    = PTR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE   = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONES  = {ADDR_BITS{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [WIDTH-1:0]        fifo_mem_r [FIFO_DEPTH];
    logic [PTR_BITS-1:0]     rd_ptr_r;
    logic [PTR_BITS-1:0]     wr_ptr_r;
    logic [PTR_BITS:0]       count_r;
    logic [PTR_BITS:0]       count_nxt_s;
    logic [ADDR_BITS-1:0]    addr_r;
    logic                    wrapped_r;
    logic                    stall_s;
    logic                    push_s;
    logic                    pop_s;
    logic [WIDTH-1:0]        word_s;

    // Field packing; op and A always occupy the top bits, the low byte
    // carries either ext/B or the immediate.
    function automatic logic [WIDTH-1:0] encode_word(
        input logic                        f_fmt,
        input logic [OP_CODE_BITS-1:0]     f_op,
        input logic [REG_BITS-1:0]         f_a,
        input logic [EXT_OP_CODE_BITS-1:0] f_ext,
        input logic [REG_BITS-1:0]         f_b,
        input logic [7:0]                  f_imm
    );
        logic [WIDTH-1:0] w;
        if (f_fmt) begin
            w = {f_op, f_a, f_imm};
        end else begin
            w = {f_op, f_a, f_ext, f_b};
        end
        return w;
    endfunction

`ifdef INSTR_ENC_WRAP_STOP_EN
    assign stall_s = wrapped_r;
`else
    assign stall_s = 1'b0;
`endif

    assign word_s = encode_word(bus.fmt, bus.op_code, bus.A_index,
                                bus.ext_op_code, bus.B_index, bus.immediate);

    // Outputs depend on registered state only; mem_ready and in_valid reach
    // nothing but the internal push/pop strobes.
    assign bus.in_ready  = (count_r < FULL_COUNT) && !stall_s;
    assign bus.mem_we    = (state_r == ST_WRITE) && !stall_s;
    assign bus.mem_wdata = (state_r == ST_WRITE) ? fifo_mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    assign bus.mem_addr  = addr_r;
    assign wrapped       = wrapped_r;
    assign count         = count_r;

    assign push_s = bus.in_valid && bus.in_ready;
    assign pop_s  = bus.mem_we && bus.mem_ready;

    // Next buffered-word count from the push/pop strobes.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // FSM next state: WRITE whenever words will be buffered after this edge,
    // so an accepted word shows up on the memory port in the very next cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_nxt_s != CNT_ZERO) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (count_nxt_s == CNT_ZERO) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_BITS{1'b0}};
            wr_ptr_r <= {PTR_BITS{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // FIFO storage; cleared on reset so no stale word is ever observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= word_s;
        end
    end

    // Write pointer and sticky wrap flag; load_addr overrides an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= {ADDR_BITS{1'b0}};
            wrapped_r <= 1'b0;
        end else if (load_addr) begin
            addr_r    <= start_addr;
            wrapped_r <= 1'b0;
        end else if (pop_s) begin
            addr_r <= addr_r + ADDR_ONE;
            if (addr_r == ADDR_ONES) begin
                wrapped_r <= 1'b1;
            end
        end
    end
endmodule
